// File: rtl/psum_requantizer.sv
// Accumulates MAC partial sums per output pixel, rounds/shifts/saturates the result
// and queues it in a small FIFO towards ODS. Optional saturation counter: SAT_COUNT_EN.
module psum_requantizer #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int SHIFT_WIDTH        = 5
) (
    input  logic                                 clk,
    input  logic                                 arst_n_in,
    input  logic                                 clear,
    input  logic [SHIFT_WIDTH-1:0]               shift_amt,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic signed [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic                                 in_first,
    input  logic                                 in_last,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic signed [IO_DATA_WIDTH-1:0]      out_data
`ifdef SAT_COUNT_EN
    ,
    output logic [15:0]                          sat_count
`endif
);

    localparam int AW = ACCUMULATION_WIDTH;
    localparam int IW = IO_DATA_WIDTH;
    localparam int PW = $clog2(FIFO_DEPTH);

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};
    localparam logic signed [IW-1:0] OUT_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] OUT_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [AW:0]   RND_ONE = 1;
    localparam logic [PW-1:0]        PTR_ONE = 1;
    localparam logic [PW:0]          CNT_ONE = 1;
    localparam logic [PW:0]          CNT_FULL = FIFO_DEPTH[PW:0];

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] base;
    logic [AW:0]          add_w;
    logic signed [AW-1:0] sum;
    logic [31:0]          sh_eff;
    logic signed [AW:0]   sum_ext;
    logic signed [AW:0]   rnd;
    logic signed [AW:0]   r;
    logic [AW-IW+1:0]     hi;
    logic                 q_sat;
    logic signed [IW-1:0] q;

    logic signed [IW-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_next;
    logic [PW:0]          count;
    logic [PW:0]          cnt_next;
    logic signed [IW-1:0] out_data_q;
    logic signed [IW-1:0] head_next;
    logic                 accept;
    logic                 push;
    logic                 pop;

    // Handshake: a beat transfers on in_valid && in_ready, a result leaves on
    // out_valid && out_ready; clear overrides both in the same cycle.
    assign in_ready  = (count != CNT_FULL);
    assign out_valid = (count != '0);
    assign out_data  = out_data_q;
    assign accept    = in_valid && in_ready && !clear;
    assign push      = accept && in_last;
    assign pop       = out_valid && out_ready && !clear;

    always_comb begin
        base  = in_first ? '0 : acc;
        add_w = {base[AW-1], base} + {in_data[AW-1], in_data};
        if (add_w[AW] != add_w[AW-1]) begin
            sum = add_w[AW] ? ACC_MIN : ACC_MAX;
        end else begin
            sum = add_w[AW-1:0];
        end

        sh_eff  = (32'(shift_amt) >= 32'(AW)) ? 32'(AW - 1) : 32'(shift_amt);
        // One extra bit keeps the rounding bias from overflowing at large sums.
        sum_ext = {sum[AW-1], sum};
        rnd     = (sh_eff == 32'd0) ? '0 : (RND_ONE << (sh_eff - 32'd1));
        r       = (sum_ext + rnd) >>> sh_eff;

        hi    = r[AW:IW-1];
        q_sat = !((&hi) || !(|hi));
        q     = q_sat ? (r[AW] ? OUT_MIN : OUT_MAX) : r[IW-1:0];
    end

    always_comb begin
        rd_next = pop ? (rd_ptr + PTR_ONE) : rd_ptr;
        case ({push, pop})
            2'b10:   cnt_next = count + CNT_ONE;
            2'b01:   cnt_next = count - CNT_ONE;
            default: cnt_next = count;
        endcase
        // A lone new entry is not in mem yet, so it is forwarded straight to the head.
        if (cnt_next == '0) begin
            head_next = out_data_q;
        end else if (push && (cnt_next == CNT_ONE)) begin
            head_next = q;
        end else begin
            head_next = mem[rd_next];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= q;
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            acc        <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            out_data_q <= '0;
        end else if (clear) begin
            acc    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) begin
                acc <= in_last ? '0 : sum;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            rd_ptr     <= rd_next;
            count      <= cnt_next;
            out_data_q <= head_next;
        end
    end

`ifdef SAT_COUNT_EN
    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            sat_count <= '0;
        end else if (clear) begin
            sat_count <= '0;
        end else if (push && q_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_psum_requantizer.sv
// Directed bench for psum_requantizer: rounding, saturation, back-pressure, clear and reset.
module tb_psum_requantizer;

    logic        clk;
    logic        arst_n_in;
    logic        clear;
    logic [4:0]  shift_amt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_first;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
`ifdef SAT_COUNT_EN
    logic [15:0] sat_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    psum_requantizer dut (
        .clk       (clk),
        .arst_n_in (arst_n_in),
        .clear     (clear),
        .shift_amt (shift_amt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef SAT_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    // clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // driver: called #1 after a rising edge, returns #1 after the accepting edge
    task automatic send_beat(input logic [31:0] d, input logic f, input logic l,
                             input logic [4:0] sh);
        int waited = 0;
        in_data   = d;
        in_first  = f;
        in_last   = l;
        shift_amt = sh;
        in_valid  = 1'b1;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    // scoreboard: pops one FIFO entry and compares it to the expected queue head
    task automatic pop_one(input string tag);
        logic [15:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, e});
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [15:0] e);
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check({tag, "_data"}, {16'd0, out_data}, {16'd0, e});
    endtask

    initial begin
        arst_n_in = 1'b0;
        clear     = 1'b0;
        shift_amt = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {16'd0, out_data}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SAT_COUNT_EN
        check("rst_sat_count", {16'd0, sat_count}, 32'd0);
`endif
        arst_n_in = 1'b1;
        idle_cycle();

        // single-beat pixel, one-cycle output pulse
        send_beat(32'd100, 1'b1, 1'b1, 5'd2);
        check_out("single", 16'd25);
        idle_cycle();
        check("single_drained", {31'd0, out_valid}, 32'd0);

        // three-beat pixel: nothing until the last beat
        send_beat(32'd1000, 1'b1, 1'b0, 5'd3);
        check("multi_b1_none", {31'd0, out_valid}, 32'd0);
        send_beat(-32'sd200, 1'b0, 1'b0, 5'd3);
        check("multi_b2_none", {31'd0, out_valid}, 32'd0);
        send_beat(32'd300, 1'b0, 1'b1, 5'd3);
        check_out("multi", 16'd138);
        idle_cycle();

        // rounding and sign handling
        send_beat(-32'sd7, 1'b1, 1'b1, 5'd1);
        check_out("round_neg", 16'hFFFD);
        send_beat(32'd5, 1'b1, 1'b1, 5'd0);
        check_out("shift0", 16'd5);
        send_beat(-32'sd9, 1'b1, 1'b1, 5'd4);
        check_out("round_neg9", 16'hFFFF);
        send_beat(32'h4000_0000, 1'b1, 1'b1, 5'd31);
        check_out("shift31", 16'd1);
        idle_cycle();

        // output and accumulator saturation
        send_beat(32'h7FFF_FFF0, 1'b1, 1'b1, 5'd0);
        check_out("sat_pos", 16'h7FFF);
`ifdef SAT_COUNT_EN
        check("sat_cnt1", {16'd0, sat_count}, 32'd1);
`endif
        send_beat(32'h8000_0000, 1'b1, 1'b1, 5'd4);
        check_out("sat_neg", 16'h8000);
`ifdef SAT_COUNT_EN
        check("sat_cnt2", {16'd0, sat_count}, 32'd2);
`endif
        send_beat(32'h7FFF_0000, 1'b1, 1'b0, 5'd16);
        send_beat(32'h7FFF_0000, 1'b0, 1'b1, 5'd16);
        check_out("acc_sat", 16'h7FFF);
`ifdef SAT_COUNT_EN
        check("sat_cnt3", {16'd0, sat_count}, 32'd3);
`endif
        idle_cycle();

        // back-pressure: fill, stall, drain in order
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send_beat(32'(i), 1'b1, 1'b1, 5'd0);
            exp_q.push_back(16'(i));
        end
        check("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        idle_cycle();
        check_out("bp_head_held", 16'd1);
        pop_one("bp_pop1");
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        send_beat(32'd5, 1'b1, 1'b1, 5'd0);
        exp_q.push_back(16'd5);
        for (int i = 2; i <= 5; i++) pop_one("bp_pop");
        check("bp_empty", {31'd0, out_valid}, 32'd0);
        check("bp_hold_last", {16'd0, out_data}, 32'd5);

        // continuous stream with simultaneous push and pop
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_beat(32'(100 + i * 7), 1'b1, 1'b1, 5'd0);
            check_out("stream", 16'(100 + i * 7));
            check("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        idle_cycle();

        // clear with a beat offered in the same cycle
        out_ready = 1'b0;
        send_beat(32'd10, 1'b1, 1'b1, 5'd0);
        send_beat(32'd20, 1'b1, 1'b1, 5'd0);
        send_beat(32'd30, 1'b1, 1'b1, 5'd0);
        send_beat(32'd50, 1'b1, 1'b0, 5'd0);
        in_data  = 32'd7;
        in_first = 1'b0;
        in_last  = 1'b1;
        in_valid = 1'b1;
        clear    = 1'b1;
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef SAT_COUNT_EN
        check("clr_sat_count", {16'd0, sat_count}, 32'd0);
`endif
        out_ready = 1'b1;
        send_beat(32'd9, 1'b0, 1'b1, 5'd0);
        check_out("after_clear", 16'd9);
        idle_cycle();

        // asynchronous reset mid-stream
        out_ready = 1'b0;
        send_beat(32'd11, 1'b1, 1'b1, 5'd0);
        send_beat(32'd12, 1'b1, 1'b1, 5'd0);
        send_beat(32'd40, 1'b1, 1'b0, 5'd0);
        #2;
        arst_n_in = 1'b0;
        #1;
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out_data", {16'd0, out_data}, 32'd0);
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        arst_n_in = 1'b1;
        out_ready = 1'b1;
        send_beat(32'd3, 1'b0, 1'b1, 5'd0);
        check_out("after_arst", 16'd3);
        idle_cycle();

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/psum_requantizer.md
Name: psum_requantizer

Overview:
- Sits between the super_MAC accumulation output (ACCUMULATION_WIDTH signed) and the ODS input (IO_DATA_WIDTH signed).
- Accumulates partial sums across input-channel tiles, then scales by an arithmetic right shift with round-half-up and saturates to IO_DATA_WIDTH.
- Buffers finished outputs in a small FIFO so ODS back-pressure does not stall the MAC in the same cycle.
- Valid/ready handshake on both sides; driven by controller_fsm.

Parameters:
- ACCUMULATION_WIDTH, 32, width of incoming partial sums and of the internal accumulator.
- IO_DATA_WIDTH, 16, width of quantized output towards ODS.
- FIFO_DEPTH, 4, number of output FIFO entries; power of two, ≥2.
- SHIFT_WIDTH, 5, width of shift_amt.

Ports:
- clk  input  1  system clock; all state on rising edge.
- arst_n_in  input  1  asynchronous reset, active low.
- clear  input  1  synchronous flush of accumulator and FIFO.
- shift_amt  input  SHIFT_WIDTH  right-shift amount, unsigned; sampled on accepted last beat.
- in_valid  input  1  partial sum valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  ACCUMULATION_WIDTH  signed partial sum from MAC.
- in_first  input  1  beat starts a new output pixel; accumulator is ignored.
- in_last  input  1  beat completes the output pixel; result is quantized and pushed.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  ODS accepts head.
- out_data  output  IO_DATA_WIDTH  signed quantized result (FIFO head).
- sat_count  output  16  saturation event count; present only with SAT_COUNT_EN.

Behaviour:
- Reset (arst_n_in=0, asynchronous): accumulator 0, FIFO empty, out_valid 0, out_data 0, in_ready 1, sat_count 0.
- Accept: in_valid && in_ready. Pop: out_valid && out_ready.
- in_ready = NOT fifo_full. Deasserts when the FIFO is full, even for non-last beats. This is conservative and keeps the logic simple.
- Sum on accept: base = in_first ? 0 : acc; sum = base + in_data. The addition saturates at the signed ACCUMULATION_WIDTH limits.
- Not in_last: acc <= sum.
- in_last: acc <= 0 and the quantized result is pushed into the FIFO in the same edge.
- in_first and in_last together form a single-beat pixel, which is legal.
- Quantization, computed in ACCUMULATION_WIDTH+1 bits:
  - if shift_amt > 0: r = (sum + 2^(shift_amt-1)) >>> shift_amt, arithmetic shift;
  - else r = sum.
  - Values of shift_amt ≥ ACCUMULATION_WIDTH are clamped to ACCUMULATION_WIDTH-1.
  - Saturate r to [-2^(IO_DATA_WIDTH-1), 2^(IO_DATA_WIDTH-1)-1]. A saturation event is recorded when clipping occurs.
- Latency: a last beat accepted at edge N is visible as out_valid=1 and out_data after edge N. There is no combinational in->out path.
- FIFO:
  - circular buffer with read/write pointers and a count;
  - out_data is the head entry and is held stable while out_valid && !out_ready;
  - entries leave in order.
- Simultaneous push and pop: allowed when not full. Count is unchanged and both pointers advance.
- When full: no push, since in_ready=0. A pop on the same edge frees a slot; in_ready rises the next cycle.
- When empty: out_valid=0 and out_data holds its last value; a pop is not possible.
- Pointer wrap-around: modulo FIFO_DEPTH.
- clear has priority over accept and pop in the same cycle. It empties the FIFO, zeroes acc, and zeroes sat_count; beats offered that cycle are dropped.
- Accepting a non-first beat after reset or clear adds onto acc=0.
- in_data is ignored when in_valid=0.
- The upstream must keep in_valid, in_data, in_first and in_last stable until accepted.

Optional Feature:
- SAT_COUNT_EN defined:
  - adds a 16-bit sat_count register;
  - increments by 1 on each pushed result that was output-saturated;
  - sticks at 0xFFFF;
  - cleared by reset and by clear.
- SAT_COUNT_EN undefined: the port and register are absent, and saturation clips silently.

Test Plan:
- Reset, then one beat in_first=in_last=1, in_data=100, shift_amt=2, out_ready=1 -> out_data=25 one cycle after accept, out_valid high for one cycle.
- Three beats 1000, -200, 300 (first on beat 1, last on beat 3), shift_amt=3 -> sum 1100, (1100+4)>>>3 = 138; no output before the third beat.
- Rounding/sign: single beat -7, shift_amt=1 -> (-7+1)>>>1 = -3. Single beat 5, shift_amt=0 -> 5.
- Saturation:
  - single beat 0x7FFF_FFF0, shift_amt=0 -> out_data=32767 (sat_count=1 with SAT_COUNT_EN);
  - single beat -2^31, shift_amt=4 -> -32768 (sat_count=2).
- Back-pressure: out_ready=0, push 5 single-beat pixels 1..5 -> in_ready=0 after 4 accepts. Raise out_ready -> outputs 1,2,3,4,5 in order with no loss. With out_ready held 1 and a continuous stream, count stays constant through simultaneous push/pop.
- Fill the FIFO with 3 entries plus a partial acc=50, then assert clear together with in_valid -> out_valid=0 next cycle, in_ready=1. The next single beat 9 with shift 0 outputs 9. Repeat with arst_n_in pulsed low mid-stream -> all outputs return to reset values immediately.
